// File: rtl/disp_clk_monitor_pkg.sv
// Shared types and defaults for the display clock monitor.
// Holds the FSM encoding, count width and window limits.
package disp_clk_monitor_pkg;

  localparam int CNT_W         = 16;
  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_MIN_CNT   = 120;
  localparam int DEF_MAX_CNT   = 136;
  localparam int DEF_SETTLE    = 256;
  localparam int DEF_RST_PULSE = 16;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_FAULT,
    ST_HOLDOFF,
    ST_DEAD
  } mon_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/disp_clk_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear on rst_n so no stale level survives reset.
module sync_2ff (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/disp_clk_monitor.sv
// Display clock frequency monitor: counts disp_tog transitions
// per window, requests PLL re-lock on faults, latches dead.
module disp_clk_monitor
  import disp_clk_monitor_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int MIN_CNT   = DEF_MIN_CNT,
  parameter int MAX_CNT   = DEF_MAX_CNT,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int RST_PULSE = DEF_RST_PULSE,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             disp_tog,
  input  logic             disp_clk_ok,
  output logic             pll_rst_req,
  output logic             clk_good,
  output logic [CNT_W-1:0] meas_count,
  output logic [1:0]       fault_cnt,
  output logic             dead
);

  logic tog_s;
  logic tog_d;
  logic ok_s;
  logic tog_edge;

  sync_2ff u_tog_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (disp_tog),
    .q      (tog_s)
  );

  sync_2ff u_ok_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (disp_clk_ok),
    .q      (ok_s)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tog_d <= 1'b0;
    else        tog_d <= tog_s;
  end

  assign tog_edge = tog_s ^ tog_d;

  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [CNT_W-1:0] ecnt_q;
  logic [CNT_W-1:0] ecnt_d;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] meas_d;
  logic [1:0]       fault_d;
  logic [1:0]       fault_inc;
  logic             good_d;
  logic             pll_d;
  logic             dead_d;
  logic             win_end;
  logic             in_range;
  logic             settle_done;
  logic             pulse_done;
  logic             retry_out;

  // Terminal-cycle edge is folded into the closing window
  assign win_cnt     = sat_inc(ecnt_q, tog_edge);
  assign win_end     = timer_q == CNT_W'(WINDOW - 1);
  assign in_range    = (win_cnt >= CNT_W'(MIN_CNT)) &&
                       (win_cnt <= CNT_W'(MAX_CNT));
  assign settle_done = timer_q == CNT_W'(SETTLE - 1);
  assign pulse_done  = timer_q == CNT_W'(RST_PULSE - 1);
  assign fault_inc   = (fault_cnt == 2'd3) ? 2'd3
                                           : fault_cnt + 2'd1;
  assign retry_out   = int'(fault_cnt) >= MAX_RETRY;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ok_s) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!ok_s)            state_d = ST_IDLE;
        else if (settle_done) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!ok_s)                     state_d = ST_FAULT;
        else if (win_end && !in_range) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (retry_out)       state_d = ST_DEAD;
        else if (pulse_done) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // Only a fresh ok after a seen drop is trusted
        if (!ok_s) state_d = ST_IDLE;
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d = '0;
    ecnt_d  = '0;
    meas_d  = meas_count;
    good_d  = clk_good;
    fault_d = fault_cnt;
    unique case (state_q)
      ST_SETTLE: begin
        if (state_d == ST_SETTLE) timer_d = timer_q + CNT_W'(1);
      end
      ST_MEASURE: begin
        if (!ok_s) begin
          good_d  = 1'b0;
          fault_d = fault_inc;
        end else if (win_end) begin
          meas_d = win_cnt;
          if (in_range) begin
            good_d  = 1'b1;
            fault_d = 2'd0;
          end else begin
            good_d  = 1'b0;
            fault_d = fault_inc;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
          ecnt_d  = win_cnt;
        end
      end
      ST_FAULT: begin
        if (state_d == ST_FAULT) timer_d = timer_q + CNT_W'(1);
      end
      ST_DEAD: begin
        good_d = 1'b0;
      end
      default: begin
        timer_d = '0;
      end
    endcase
    pll_d  = (state_d == ST_FAULT) && (int'(fault_d) < MAX_RETRY);
    dead_d = state_d == ST_DEAD;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      ecnt_q      <= '0;
      meas_count  <= '0;
      clk_good    <= 1'b0;
      fault_cnt   <= 2'd0;
      pll_rst_req <= 1'b0;
      dead        <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      ecnt_q      <= ecnt_d;
      meas_count  <= meas_d;
      clk_good    <= good_d;
      fault_cnt   <= fault_d;
      pll_rst_req <= pll_d;
      dead        <= dead_d;
    end
  end

endmodule

// File: tb/tb_disp_clk_monitor.sv
// Directed-random bench for disp_clk_monitor with a window-level
// model built from recorded disp_tog flip times.
module tb_disp_clk_monitor;

  localparam int WINDOW    = 1024;
  localparam int MIN_CNT   = 120;
  localparam int MAX_CNT   = 136;
  localparam int SETTLE    = 256;
  localparam int RST_PULSE = 16;
  localparam int MAX_RETRY = 3;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_tog = 1'b0;
  logic        disp_clk_ok = 1'b0;
  logic        pll_rst_req;
  logic        clk_good;
  logic [15:0] meas_count;
  logic [1:0]  fault_cnt;
  logic        dead;

  disp_clk_monitor #(
    .WINDOW    (WINDOW),
    .MIN_CNT   (MIN_CNT),
    .MAX_CNT   (MAX_CNT),
    .SETTLE    (SETTLE),
    .RST_PULSE (RST_PULSE),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .disp_tog    (disp_tog),
    .disp_clk_ok (disp_clk_ok),
    .pll_rst_req (pll_rst_req),
    .clk_good    (clk_good),
    .meas_count  (meas_count),
    .fault_cnt   (fault_cnt),
    .dead        (dead)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Flip schedule indexed by the posedge that first samples it
  bit plan [0:65535];
  int flips [$];

  always @(negedge clk_in) begin
    if (cyc + 1 < 65536 && plan[cyc + 1]) begin
      disp_tog = ~disp_tog;
      flips.push_back(cyc + 1);
    end
  end

  int total = 0;
  int bad = 0;
  int meas_m = 0;
  int good_m = 0;
  int fault_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // Transitions land in the count three samples after arrival
  function automatic int model_count(input int lo, input int hi);
    int n = 0;
    foreach (flips[i])
      if (flips[i] + 2 >= lo && flips[i] + 2 <= hi) n++;
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic plan_window(input int w0, input int n,
                             input int period);
    int placed = 0;
    int p;
    if (period > 0) begin
      for (int k = 0; k < n; k++) plan[w0 - 1 + k * period] = 1'b1;
    end else begin
      while (placed < n) begin
        p = $urandom_range(WINDOW - 1, 0);
        if (!plan[w0 - 1 + p]) begin
          plan[w0 - 1 + p] = 1'b1;
          placed++;
        end
      end
    end
  endtask

  task automatic fault_step();
    good_m  = 0;
    fault_m = (fault_m >= 3) ? 3 : fault_m + 1;
  endtask

  task automatic check_window(input int w0, input string tag);
    int cnt;
    wait_until(w0 + WINDOW - 1);
    chk({tag, "_meas_hold"}, meas_count, meas_m);
    tick(1);
    cnt = model_count(w0 + 1, w0 + WINDOW);
    meas_m = cnt;
    if (cnt >= MIN_CNT && cnt <= MAX_CNT) begin
      good_m  = 1;
      fault_m = 0;
    end else begin
      fault_step();
    end
    chk({tag, "_meas"}, meas_count, meas_m);
    chk({tag, "_good"}, clk_good, good_m);
    chk({tag, "_fault"}, fault_cnt, fault_m);
  endtask

  task automatic check_pulse(input string tag);
    int n = 0;
    int exp_len;
    exp_len = (fault_m < MAX_RETRY) ? RST_PULSE : 0;
    chk({tag, "_pll_first"}, pll_rst_req, exp_len > 0);
    for (int i = 0; i < 40; i++) begin
      if (pll_rst_req) n++;
      tick(1);
    end
    chk({tag, "_pll_len"}, n, exp_len);
    chk({tag, "_dead"}, dead, fault_m >= MAX_RETRY);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pll"}, pll_rst_req, 0);
    chk({tag, "_good"}, clk_good, 0);
    chk({tag, "_meas"}, meas_count, 0);
    chk({tag, "_fault"}, fault_cnt, 0);
    chk({tag, "_dead"}, dead, 0);
  endtask

  // Returns the edge at which the first measurement window opens
  task automatic raise_ok(output int w0);
    disp_clk_ok = 1'b1;
    w0 = cyc + 1 + SETTLE + 2;
  endtask

  task automatic toggle_ok(output int w0);
    disp_clk_ok = 1'b0;
    tick(4);
    raise_ok(w0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int e;
    int cnts [6];

    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    cnts[0] = 128;
    cnts[1] = $urandom_range(MAX_CNT, MIN_CNT);
    cnts[2] = $urandom_range(MAX_CNT, MIN_CNT);
    cnts[3] = MIN_CNT;
    cnts[4] = MAX_CNT;
    cnts[5] = MAX_CNT + 1;
    raise_ok(w);
    for (int i = 0; i < 6; i++)
      plan_window(w + i * WINDOW, cnts[i], (i == 0) ? 8 : 0);
    for (int i = 0; i < 6; i++) begin
      check_window(w + i * WINDOW, $sformatf("win%0d", i));
      if (fault_m > 0) break;
    end
    check_pulse("hi_fault");

    toggle_ok(w);
    plan_window(w, MIN_CNT - 1, 0);
    check_window(w, "lo_win");
    check_pulse("lo_fault");

    toggle_ok(w);
    check_window(w, "stuck_win");
    check_pulse("third_fault");
    toggle_ok(w);
    tick(SETTLE + 40);
    chk("dead_sticky", dead, 1);
    chk("dead_good", clk_good, 0);
    chk("dead_pll", pll_rst_req, 0);
    chk("dead_fault", fault_cnt, 3);

    rst_n = 1'b0;
    disp_clk_ok = 1'b0;
    meas_m = 0;
    good_m = 0;
    fault_m = 0;
    tick(2);
    check_zero("reset2");
    rst_n = 1'b1;
    tick(2);

    raise_ok(w);
    check_window(w, "stuck2_win");
    check_pulse("stuck2_fault");

    toggle_ok(w);
    plan_window(w, $urandom_range(MAX_CNT, MIN_CNT), 0);
    plan_window(w + WINDOW, 128, 0);
    check_window(w, "pre_drop_win");
    w = w + WINDOW;
    wait_until(w + 499);
    disp_clk_ok = 1'b0;
    wait_until(w + 501);
    chk("drop_pll_early", pll_rst_req, 0);
    tick(1);
    fault_step();
    chk("drop_meas_kept", meas_count, meas_m);
    chk("drop_fault", fault_cnt, fault_m);
    chk("drop_good", clk_good, good_m);
    check_pulse("drop_fault");

    raise_ok(w);
    e = w + WINDOW;
    check_window(w, "rst_win");
    wait_until(e + 5);
    chk("rst_pulse_on", pll_rst_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    meas_m = 0;
    good_m = 0;
    fault_m = 0;
    check_zero("async_rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_clk_monitor.md
DISP_CLK_MONITOR -- requirements
Module: disp_clk_monitor

Interface
REQ-001 Parameter WINDOW, 1024, measurement window length in clk_in cycles.
REQ-002 Parameter MIN_CNT, 120, lowest legal transition count per window.
REQ-003 Parameter MAX_CNT, 136, highest legal transition count per window.
REQ-004 Parameter SETTLE, 256, clk_in cycles waited after disp_clk_ok before the first window.
REQ-005 Parameter RST_PULSE, 16, clk_in cycles pll_rst_req stays high per fault.
REQ-006 Parameter MAX_RETRY, 3, consecutive faults tolerated before DEAD.
REQ-007 Port clk_in, input, 1, free-running reference clock; the only clock.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port disp_tog, input, 1, asynchronous; flips once per divided disp_clk period, driven from the disp_clk domain.
REQ-010 Port disp_clk_ok, input, 1, asynchronous clock-ready flag from the display clock manager.
REQ-011 Port pll_rst_req, output, 1, re-lock request returned to the display clock manager reset input.
REQ-012 Port clk_good, output, 1, last completed window was in range.
REQ-013 Port meas_count, output, 16, transition count of the last completed window.
REQ-014 Port fault_cnt, output, 2, consecutive fault count, saturating.
REQ-015 Port dead, output, 1, sticky; retries exhausted.

Function
REQ-016 disp_tog and disp_clk_ok each SHALL pass through a 2-flop synchronizer; a third flop on disp_tog SHALL feed an XOR edge detector, so any transition counts once, 3 cycles after it arrives.
REQ-017 FSM states SHALL be IDLE, SETTLE, MEASURE, FAULT, HOLDOFF, DEAD.
REQ-018 IDLE: wait for synchronized ok=1, then go to SETTLE with timer cleared.
REQ-019 SETTLE: count SETTLE cycles, then go to MEASURE; ok=0 returns to IDLE.
REQ-020 MEASURE: a 16-bit window timer runs 0..WINDOW-1; the edge counter saturates at 16'hFFFF.
REQ-021 At window end, meas_count SHALL load the count on the same edge.
REQ-022 At window end, a count in [MIN_CNT, MAX_CNT] inclusive SHALL set clk_good=1, clear fault_cnt, and restart MEASURE with the counter at 0; an edge on the terminal cycle counts toward the closing window.
REQ-023 At window end, an out-of-range count SHALL clear clk_good, increment fault_cnt (saturating at 3), and go to FAULT.
REQ-024 Synchronized ok falling during MEASURE SHALL go to FAULT immediately, with the same fault_cnt update and meas_count left unchanged.
REQ-025 FAULT: if fault_cnt has reached MAX_RETRY, go to DEAD; otherwise assert pll_rst_req for exactly RST_PULSE cycles, then go to HOLDOFF.
REQ-026 HOLDOFF: wait for synchronized ok=0, then go to IDLE, so a stale ok is never trusted.
REQ-027 DEAD: dead=1, pll_rst_req=0, clk_good=0; exit only through rst_n.
REQ-028 pll_rst_req and clk_good SHALL be registered outputs, glitch-free.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE and clear all counters and synchronizers.
REQ-030 rst_n low SHALL force pll_rst_req=0, clk_good=0, meas_count=0, fault_cnt=0, dead=0.
REQ-031 Reset release SHALL be synchronous to clk_in; reset mid-window discards the partial count.

Structure
REQ-032 A shared package SHALL hold the state enum, the default WINDOW/MIN_CNT/MAX_CNT/SETTLE/RST_PULSE values, and the 16-bit count width constant.
REQ-033 One sub-module, sync_2ff (1-bit, rst_n-cleared), SHALL be instantiated for each asynchronous input.

Verification
REQ-034 Scenario: disp_tog flipping every 8 clk_in cycles, ok=1 -> after SETTLE+1024+4 cycles meas_count=128 and clk_good=1.
REQ-035 Scenario: disp_tog stuck -> meas_count=0, pll_rst_req high for 16 cycles, fault_cnt=1.
REQ-036 Scenario: three consecutive bad windows, each followed by an ok toggle -> third fault gives dead=1 with no third pulse.
REQ-037 Scenario: ok drops at cycle 500 of a window -> FAULT next state and a 16-cycle pll_rst_req; meas_count is kept.
REQ-038 Scenario: counts of 120 and 136 pass and counts of 119 and 137 fail, checking the boundaries.
REQ-039 Scenario: rst_n asserted during the pll_rst_req pulse -> output drops within the same cycle asynchronously and all outputs read 0.
